// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: parametrised, registered request arbiter.
// This is the successor to the 8-to-3 priority encoder.
// The mode input selects fixed priority (highest index wins) or round-robin.
// Results leave through a valid/ready output stage that can stall.
// Optional build macro PRIO_RR_ARBITER_GRANT_CNT_EN adds a saturating 16-bit
// grant_cnt output, which counts accepted grants.
module prio_rr_arbiter #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant
`ifdef PRIO_RR_ARBITER_GRANT_CNT_EN
  ,
  output logic [15:0]  grant_cnt
`endif
);

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  mode_e        mode_sel;
  logic         load;
  logic         any_req;

  // Round-robin search start: the highest-priority index for the next search.
  logic [W-1:0] ptr;

  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_grant;
  logic [W-1:0] ptr_next;

  assign mode_sel = mode_e'(mode);
  assign load     = !out_valid || out_ready;
  assign any_req  = |req;

  // Fixed priority: the highest set bit wins, so a later set bit overrides an earlier one.
  always_comb begin
    fixed_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        fixed_idx = W'(i);
      end
    end
  end

  // Round-robin: walk downward from ptr with wrap from 0 to N-1; the first hit wins.
  always_comb begin
    logic found;
    found  = 1'b0;
    rr_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (int'(ptr) + N - k) % N;
      if (!found && req[W'(j)]) begin
        found  = 1'b1;
        rr_idx = W'(j);
      end
    end
  end

  // Winner selection and its one-hot form.
  always_comb begin
    win_idx   = (mode_sel == MODE_RR) ? rr_idx : fixed_idx;
    win_grant = '0;
    win_grant[win_idx] = 1'b1;
  end

  // Pointer successor: the slot just below the winner, wrapping at 0.
  always_comb begin
    ptr_next = ptr;
    if (load && any_req && (mode_sel == MODE_RR)) begin
      ptr_next = (win_idx == '0) ? W'(N - 1) : (win_idx - 1'b1);
    end
  end

  // Output register: load a new result when empty or accepted, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      ptr       <= W'(N - 1);
    end else begin
      ptr <= ptr_next;
      if (load) begin
        if (any_req) begin
          out_valid <= 1'b1;
          out_idx   <= win_idx;
          out_grant <= win_grant;
        end else begin
          out_valid <= 1'b0;
          out_idx   <= '0;
          out_grant <= '0;
        end
      end
    end
  end

`ifdef PRIO_RR_ARBITER_GRANT_CNT_EN
  // Handshake counter; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (out_valid && out_ready && (grant_cnt != '1)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed testbench for prio_rr_arbiter (N=8), with hand-computed expectations.
module tb_prio_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_grant;
`ifdef PRIO_RR_ARBITER_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  prio_rr_arbiter #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_grant (out_grant)
`ifdef PRIO_RR_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 8'hFF; mode = 1'b0; out_ready = 1'b1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({out_valid, out_idx, out_grant} !== {1'b0, 3'd0, 8'h00}) begin
        miscompares++;
        $display("FAIL reset_cycle%0d: got v=%b idx=%0d g=%h, want v=0 idx=0 g=00",
                 i, out_valid, out_idx, out_grant);
      end
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({out_valid, out_idx, out_grant} !== {1'b1, 3'd7, 8'h80}) begin
      miscompares++;
      $display("FAIL reset_first_grant: got v=%b idx=%0d g=%h, want v=1 idx=7 g=80",
               out_valid, out_idx, out_grant);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; out_ready = 1'b1; req = 8'b0010_0110;
    step();
    vectors++;
    if ({out_valid, out_idx, out_grant} !== {1'b1, 3'd5, 8'b0010_0000}) begin
      miscompares++;
      $display("FAIL fixed_26: got v=%b idx=%0d g=%h, want v=1 idx=5 g=20",
               out_valid, out_idx, out_grant);
    end
    req = 8'h01;
    step();
    vectors++;
    if ({out_valid, out_idx, out_grant} !== {1'b1, 3'd0, 8'h01}) begin
      miscompares++;
      $display("FAIL fixed_01: got v=%b idx=%0d g=%h, want v=1 idx=0 g=01",
               out_valid, out_idx, out_grant);
    end
  endtask

  task automatic test_stall();
    mode = 1'b0; out_ready = 1'b1; req = 8'b0010_0110;
    step();
    out_ready = 1'b0; req = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({out_valid, out_idx, out_grant} !== {1'b1, 3'd5, 8'h20}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got v=%b idx=%0d g=%h, want v=1 idx=5 g=20",
                 i, out_valid, out_idx, out_grant);
      end
      mode = ~mode;
    end
    mode = 1'b0; out_ready = 1'b1;
    step();
    vectors++;
    if ({out_valid, out_idx, out_grant} !== {1'b1, 3'd7, 8'h80}) begin
      miscompares++;
      $display("FAIL stall_release: got v=%b idx=%0d g=%h, want v=1 idx=7 g=80",
               out_valid, out_idx, out_grant);
    end
  endtask

  task automatic test_rr_fairness();
    int exp_seq[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    logic [7:0] one = 8'h01;
    mode = 1'b1; out_ready = 1'b1; req = 8'hFF; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({out_valid, out_idx, out_grant} !== {1'b1, 3'(exp_seq[i]), one << exp_seq[i]}) begin
        miscompares++;
        $display("FAIL rr_fair%0d: got v=%b idx=%0d g=%h, want v=1 idx=%0d g=%h",
                 i, out_valid, out_idx, out_grant, exp_seq[i], one << exp_seq[i]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    int exp_seq[7] = '{7, 0, 7, 0, 7, 7, 7};
    logic [7:0] one = 8'h01;
    mode = 1'b1; out_ready = 1'b1; req = 8'b1000_0001; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) mode = 1'b0;
      step();
      vectors++;
      if ({out_valid, out_idx, out_grant} !== {1'b1, 3'(exp_seq[i]), one << exp_seq[i]}) begin
        miscompares++;
        $display("FAIL rr_wrap%0d: got v=%b idx=%0d g=%h, want v=1 idx=%0d g=%h",
                 i, out_valid, out_idx, out_grant, exp_seq[i], one << exp_seq[i]);
      end
    end
  endtask

  task automatic test_rr_single();
    mode = 1'b1; out_ready = 1'b1; req = 8'b0000_1000; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({out_valid, out_idx, out_grant} !== {1'b1, 3'd3, 8'h08}) begin
        miscompares++;
        $display("FAIL rr_single%0d: got v=%b idx=%0d g=%h, want v=1 idx=3 g=08",
                 i, out_valid, out_idx, out_grant);
      end
    end
  endtask

  task automatic test_empty_and_counter();
    mode = 1'b0; out_ready = 1'b1; req = 8'h01; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    req = 8'h00;
    step();
    vectors++;
    if ({out_valid, out_idx, out_grant} !== {1'b0, 3'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL empty: got v=%b idx=%0d g=%h, want v=0 idx=0 g=00",
               out_valid, out_idx, out_grant);
    end
`ifdef PRIO_RR_ARBITER_GRANT_CNT_EN
    vectors++;
    if (grant_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL cnt_after4: got %0d, want 4", grant_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (grant_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL cnt_reset: got %0d, want 0", grant_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; req = '0; mode = 1'b0; out_ready = 1'b1;
    #1;
    test_reset();
    test_fixed();
    test_stall();
    test_rr_fairness();
    test_rr_wrap();
    test_rr_single();
    test_empty_and_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
